// File: rtl/brick_field_renderer_if.sv
// Hit-clear handshake between the collision logic (master) and the brick field (slave).
interface brick_field_renderer_if;
  logic       hit_req;
  logic [2:0] hit_col;
  logic [1:0] hit_row;
  logic       hit_ack;
  logic       hit_was_alive;

  // Master raises hit_req with hit_col/hit_row stable and holds it until hit_ack.
  // hit_ack is a one-cycle pulse, and hit_was_alive is meaningful only while it is high.
  // hit_req is sampled only in cycles where hit_ack is low, so a request held through
  // the ack cycle is counted once.
  modport master (
    output hit_req, hit_col, hit_row,
    input  hit_ack, hit_was_alive
  );

  modport slave (
    input  hit_req, hit_col, hit_row,
    output hit_ack, hit_was_alive
  );
endinterface

// File: rtl/brick_field_renderer.sv
// Brick field pixel stage: alive-map lookup, sprite ROM addressing, two-cycle index pipeline,
// hit-clear handshake and bricks-left tracking.
module brick_field_renderer #(
  parameter int COLS         = 8,
  parameter int ROWS         = 4,
  parameter int BRICK_W_LOG2 = 5,
  parameter int BRICK_H_LOG2 = 4,
  parameter int FIELD_X0     = 64,
  parameter int FIELD_Y0     = 48
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   pix_en,
  input  logic [9:0]                             DrawX,
  input  logic [9:0]                             DrawY,
  input  logic                                   vid_on,
  input  logic                                   load,
  brick_field_renderer_if.slave                  hit,
  output logic [BRICK_H_LOG2+BRICK_W_LOG2-1:0]   rom_addr,
  input  logic [3:0]                             rom_data,
  output logic [3:0]                             index,
  output logic                                   index_valid,
  output logic [$clog2(COLS*ROWS+1)-1:0]         bricks_left,
  output logic                                   all_clear
);

  localparam int N  = COLS * ROWS;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(N + 1);

  localparam logic [10:0] X0     = 11'(FIELD_X0);
  localparam logic [10:0] Y0     = 11'(FIELD_Y0);
  localparam logic [10:0] X_SPAN = 11'(COLS << BRICK_W_LOG2);
  localparam logic [10:0] Y_SPAN = 11'(ROWS << BRICK_H_LOG2);
  localparam logic [3:0]  COLS_L = 4'(COLS);

  logic [N-1:0]   alive;
  logic           s1_v;
  logic           s2_v;

  logic [10:0]    dx, dy, rel_x, rel_y;
  logic           in_field;
  logic [CW-1:0]  pix_col;
  logic [RW-1:0]  pix_row;
  logic [IW-1:0]  pix_idx;
  logic           pix_live;

  logic           hit_take;
  logic [IW-1:0]  hit_idx;
  logic           hit_clears;

  always_comb begin
    dx       = {1'b0, DrawX};
    dy       = {1'b0, DrawY};
    rel_x    = dx - X0;
    rel_y    = dy - Y0;
    // Lower bound guards against the subtraction wrapping for pixels left of / above the field.
    in_field = (dx >= X0) && (rel_x < X_SPAN) && (dy >= Y0) && (rel_y < Y_SPAN);
    pix_col  = rel_x[BRICK_W_LOG2 +: CW];
    pix_row  = rel_y[BRICK_H_LOG2 +: RW];
    pix_idx  = IW'(pix_row) * IW'(COLS) + IW'(pix_col);
    pix_live = pix_en & vid_on & in_field & alive[pix_idx];
  end

  always_comb begin
    hit_take   = hit.hit_req & ~hit.hit_ack;
    hit_idx    = IW'(hit.hit_row) * IW'(COLS) + IW'(hit.hit_col);
    // A load in the same cycle restores the map, so the hit is acknowledged as a miss.
    hit_clears = hit_take & ~load & ({1'b0, hit.hit_col} < COLS_L)
               & alive[hit_idx] & (bricks_left != '0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      alive             <= '1;
      bricks_left       <= BW'(N);
      all_clear         <= 1'b0;
      hit.hit_ack       <= 1'b0;
      hit.hit_was_alive <= 1'b0;
      rom_addr          <= '0;
      s1_v              <= 1'b0;
      s2_v              <= 1'b0;
    end else begin
      rom_addr          <= {rel_y[BRICK_H_LOG2-1:0], rel_x[BRICK_W_LOG2-1:0]};
      s1_v              <= pix_live;
      s2_v              <= s1_v;
      hit.hit_ack       <= hit_take;
      hit.hit_was_alive <= hit_clears;
      all_clear         <= (bricks_left == '0);
      if (load) begin
        alive       <= '1;
        bricks_left <= BW'(N);
      end else if (hit_clears) begin
        alive[hit_idx] <= 1'b0;
        bricks_left    <= bricks_left - BW'(1);
      end
    end
  end

  // ROM data for the stage-1 address lands this cycle, aligned with s2_v.
  assign index       = s2_v ? rom_data : 4'h0;
  assign index_valid = s2_v;

endmodule
